// File: rtl/matrix_stream_arbiter_pkg.sv
// matrix_ip_pkg: shared state type, frame geometry and round-robin pick for the matrix stream arbiter
package matrix_ip_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int DEF_SIZE = 4;
  localparam int DEF_NUM_REQ = 2;
  localparam int FRAME = DEF_SIZE * DEF_SIZE;
  localparam int CNT_W = $clog2(FRAME);
  localparam int ID_W = $clog2(DEF_NUM_REQ);
  // Nearest valid requester at or after ptr, wrapping; scanned far-to-near so the nearest wins.
  function automatic int rr_pick(input logic [7:0] valid, input int n, input int ptr);
    int pick;
    pick = ptr;
    for (int k = 7; k >= 0; k--)
      if (k < n && valid[(ptr + k) % n]) pick = (ptr + k) % n;
    return pick;
  endfunction
endpackage

// File: rtl/matrix_stream_arbiter_if.sv
// matrix_stream_arbiter_if: requester, engine and response stream bundle for the matrix stream arbiter
interface matrix_stream_arbiter_if
  import matrix_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = DEF_NUM_REQ
);
  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
  logic [NUM_REQ-1:0] req_tvalid, req_tlast, req_tready;
  logic [DATA_WIDTH-1:0] eng_in_tdata, eng_out_tdata, rsp_tdata;
  logic eng_in_tvalid, eng_in_tlast, eng_in_tready;
  logic eng_out_tvalid, eng_out_tlast, eng_out_tready;
  logic [NUM_REQ-1:0] rsp_tvalid, rsp_tlast, rsp_tready;
  modport slave (
    input req_tdata, req_tvalid, req_tlast, eng_in_tready,
    input eng_out_tdata, eng_out_tvalid, eng_out_tlast, rsp_tready,
    output req_tready, eng_in_tdata, eng_in_tvalid, eng_in_tlast,
    output eng_out_tready, rsp_tdata, rsp_tvalid, rsp_tlast
  );
  modport master (
    output req_tdata, req_tvalid, req_tlast, eng_in_tready,
    output eng_out_tdata, eng_out_tvalid, eng_out_tlast, rsp_tready,
    input req_tready, eng_in_tdata, eng_in_tvalid, eng_in_tlast,
    input eng_out_tready, rsp_tdata, rsp_tvalid, rsp_tlast
  );
endinterface

// File: rtl/matrix_stream_arbiter_tag_fifo.sv
// arb_tag_fifo: small synchronous FIFO holding the requester id of each matrix in flight
module arb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] cnt;
  logic push_ok, pop_ok;
  assign full = cnt == OW'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign pop_ok = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      cnt <= cnt + OW'(push_ok) - OW'(pop_ok);
    end
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
endmodule

// File: rtl/matrix_stream_arbiter.sv
// matrix_stream_arbiter: whole-matrix round-robin sharing of one matrix engine with tagged result routing.
// Optional ARB_TLAST_CHECK_EN adds a sticky frame_err tlast consistency flag.
module matrix_stream_arbiter
  import matrix_ip_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TAG_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  matrix_stream_arbiter_if.slave bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic busy
`ifdef ARB_TLAST_CHECK_EN
  , output logic frame_err
`endif
);
  localparam int FRM = SIZE * SIZE;
  localparam int CW = $clog2(FRM);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [IW-1:0] rr_ptr, pick, head;
  logic [CW-1:0] in_cnt, out_cnt;
  logic full, empty, push, pop, in_hs, out_hs, in_last, out_last, xfer;
  assign xfer = state == XFER;
  assign pick = IW'(rr_pick(8'(bus.req_tvalid), NUM_REQ, int'(rr_ptr)));
  assign push = !xfer && |bus.req_tvalid && !full;
  assign in_last = in_cnt == CW'(FRM - 1);
  assign out_last = out_cnt == CW'(FRM - 1);
  assign in_hs = xfer && bus.req_tvalid[grant_id] && bus.eng_in_tready;
  assign out_hs = !empty && bus.eng_out_tvalid && bus.rsp_tready[head];
  assign pop = out_hs && out_last;
  assign busy = xfer || !empty;
  assign bus.eng_in_tdata = bus.req_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign bus.eng_in_tvalid = xfer && bus.req_tvalid[grant_id];
  assign bus.eng_in_tlast = in_last;
  assign bus.req_tready = xfer ? NUM_REQ'(bus.eng_in_tready) << grant_id : '0;
  assign bus.eng_out_tready = !empty && bus.rsp_tready[head];
  assign bus.rsp_tdata = bus.eng_out_tdata;
  assign bus.rsp_tvalid = empty ? '0 : NUM_REQ'(bus.eng_out_tvalid) << head;
  assign bus.rsp_tlast = empty ? '0 : NUM_REQ'(bus.eng_out_tlast) << head;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      in_cnt <= '0;
    end else if (!xfer) begin
      if (push) begin
        grant_id <= pick;
        state <= XFER;
      end
    end else if (in_hs) begin
      in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      if (in_last) begin
        state <= IDLE;
        rr_ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) out_cnt <= '0;
    else if (out_hs) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
  end
  // Tags are pushed at grant time so results route in engine (grant) order.
  arb_tag_fifo #(.DEPTH(TAG_DEPTH), .W(IW)) u_tags (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(pick),
    .head(head), .full(full), .empty(empty)
  );
`ifdef ARB_TLAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else if ((in_hs && bus.req_tlast[grant_id] != in_last) || (out_hs && bus.eng_out_tlast != out_last))
      frame_err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = ^bus.req_tlast;
`endif
endmodule

// File: tb/tb_matrix_stream_arbiter.sv
// tb_matrix_stream_arbiter: randomized bench with a transposing engine model and a queue-based arbiter reference
module tb_matrix_stream_arbiter;
  localparam int N = 2, DW = 32, FR = 16;
  logic clk = 0, rst = 1;
  logic [0:0] grant_id;
  logic busy;
`ifdef ARB_TLAST_CHECK_EN
  logic frame_err;
`endif
  matrix_stream_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus();
  matrix_stream_arbiter #(.SIZE(4), .DATA_WIDTH(DW), .NUM_REQ(N), .TAG_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_id(grant_id), .busy(busy)
`ifdef ARB_TLAST_CHECK_EN
    , .frame_err(frame_err)
`endif
  );
  always #5 clk = ~clk;
  int pass_n = 0, total_n = 0;
  int p_valid[N], p_rsp[N], p_in, p_ov;
  bit rst_req;
  int bad_beat = -1;
  int sf[N], sb[N], rf[N], rb[N];
  logic [DW-1:0] fill[FR];
  int fill_cnt, out_pos;
  logic [DW-1:0] out_q[$];
  bit m_xfer, m_err;
  int m_gid, m_ptr, m_inb, m_outb;
  int tags[$];
  int dut_grants[$];
  int in_tl, in_beats;

  function automatic logic [DW-1:0] mk(int r, int f, int b);
    return {4'(r), 12'(f), 16'(b)};
  endfunction
  function automatic int tr(int k);
    return (k % 4) * 4 + k / 4;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_xfer = 0; m_err = 0; m_gid = 0; m_ptr = 0; m_inb = 0; m_outb = 0;
    tags.delete();
    fill_cnt = 0; out_pos = 0;
    out_q.delete();
    for (int r = 0; r < N; r++) begin sf[r] = 0; sb[r] = 0; rf[r] = 0; rb[r] = 0; end
  endtask

  task automatic step();
    logic [N-1:0] v, rr, rt;
    logic ov, ir, tl;
    bit ne, full;
    int h, p;
    @(negedge clk);
    rst = rst_req;
    for (int r = 0; r < N; r++) begin
      v[r] = $urandom_range(99) < p_valid[r];
      rr[r] = $urandom_range(99) < p_rsp[r];
      bus.req_tdata[r*DW +: DW] = mk(r, sf[r], sb[r]);
      bus.req_tlast[r] = sb[r] == FR - 1 || sb[r] == bad_beat;
    end
    ir = $urandom_range(99) < p_in && out_q.size() + fill_cnt < 2 * FR;
    ov = out_q.size() > 0 && $urandom_range(99) < p_ov;
    tl = ov && out_pos == FR - 1;
    bus.req_tvalid = v;
    bus.eng_in_tready = ir;
    bus.eng_out_tvalid = ov;
    bus.eng_out_tdata = '0;
    if (ov) bus.eng_out_tdata = out_q[0];
    bus.eng_out_tlast = tl;
    bus.rsp_tready = rr;
    #1;
    ne = tags.size() > 0;
    h = ne ? tags[0] : 0;
    if (rst) model_reset();
    else begin
      chk("grant_id", grant_id, m_gid);
      chk("busy", busy, m_xfer || ne);
      chk("req_tready", bus.req_tready, (m_xfer && ir) ? (1 << m_gid) : 0);
      chk("eng_in_tvalid", bus.eng_in_tvalid, m_xfer && v[m_gid]);
      if (m_xfer && v[m_gid]) begin
        chk("eng_in_tdata", bus.eng_in_tdata, mk(m_gid, sf[m_gid], sb[m_gid]));
        chk("eng_in_tlast", bus.eng_in_tlast, m_inb == FR - 1);
      end
      chk("eng_out_tready", bus.eng_out_tready, ne && rr[h]);
      chk("rsp_tvalid", bus.rsp_tvalid, (ne && ov) ? (1 << h) : 0);
      chk("rsp_tlast", bus.rsp_tlast, (ne && tl) ? (1 << h) : 0);
`ifdef ARB_TLAST_CHECK_EN
      chk("frame_err", frame_err, m_err);
`endif
      rt = bus.req_tready;
      for (int r = 0; r < N; r++)
        if (bus.rsp_tvalid[r] && rr[r]) begin
          chk("rsp_tdata", bus.rsp_tdata, mk(r, rf[r], tr(rb[r])));
          rb[r]++;
          if (rb[r] == FR) begin rb[r] = 0; rf[r]++; end
        end
      for (int r = 0; r < N; r++)
        if (v[r] && rt[r]) begin
          sb[r]++;
          if (sb[r] == FR) begin sb[r] = 0; sf[r]++; end
        end
      if (bus.eng_in_tvalid && ir) begin
        if (fill_cnt == 0) dut_grants.push_back(int'(grant_id));
        fill[fill_cnt] = bus.eng_in_tdata;
        fill_cnt++;
        in_beats++;
        if (bus.eng_in_tlast) in_tl++;
        if (fill_cnt == FR) begin
          for (int k = 0; k < FR; k++) out_q.push_back(fill[tr(k)]);
          fill_cnt = 0;
        end
      end
      if (ov && bus.eng_out_tready) begin
        void'(out_q.pop_front());
        out_pos = (out_pos + 1) % FR;
      end
      // Reference: whole-frame grants, tag queue bounded at two, results routed by queue head.
      full = tags.size() >= 2;
      if (!m_xfer) begin
        if (|v && !full) begin
          p = m_ptr;
          for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) begin p = (m_ptr + k) % N; break; end
          m_gid = p;
          tags.push_back(p);
          m_xfer = 1;
        end
      end else if (v[m_gid] && ir) begin
        if (bus.req_tlast[m_gid] != (m_inb == FR - 1)) m_err = 1;
        m_inb++;
        if (m_inb == FR) begin m_inb = 0; m_xfer = 0; m_ptr = (m_gid + 1) % N; end
      end
      if (ne && ov && rr[h]) begin
        if (tl != (m_outb == FR - 1)) m_err = 1;
        m_outb++;
        if (m_outb == FR) begin m_outb = 0; void'(tags.pop_front()); end
      end
    end
    @(posedge clk);
  endtask

  task automatic set_all(int pv, int pr, int pi, int po);
    for (int r = 0; r < N; r++) begin p_valid[r] = pv; p_rsp[r] = pr; end
    p_in = pi;
    p_ov = po;
  endtask

  task automatic do_rst();
    rst_req = 1;
    step();
    rst_req = 0;
  endtask

  initial begin
    set_all(0, 0, 0, 0);
    rst_req = 1;
    repeat (3) step();
    rst_req = 0;
    step();
    #1;
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_tready", bus.req_tready, 0);
    chk("rst_eng_in_tvalid", bus.eng_in_tvalid, 0);
    chk("rst_eng_out_tready", bus.eng_out_tready, 0);
    chk("rst_rsp_tvalid", bus.rsp_tvalid, 0);

    set_all(0, 100, 100, 100);
    p_valid[0] = 100;
    in_tl = 0; in_beats = 0;
    for (int i = 0; i < 100 && sf[0] == 0; i++) step();
    p_valid[0] = 0;
    chk("single_frame_sent", sf[0], 1);
    repeat (50) step();
    chk("single_in_beats", in_beats, 16);
    chk("single_in_tlast", in_tl, 1);
    chk("single_rsp_frames", rf[0], 1);
    chk("single_rsp_other", rf[1] * FR + rb[1], 0);
    #1 chk("single_idle_busy", busy, 0);

    do_rst();
    dut_grants.delete();
    set_all(100, 100, 100, 100);
    repeat (80) step();
    chk("rr_grant_count", dut_grants.size() >= 3, 1);
    chk("rr_grant0", dut_grants.size() > 0 ? dut_grants[0] : 99, 0);
    chk("rr_grant1", dut_grants.size() > 1 ? dut_grants[1] : 99, 1);
    chk("rr_grant2", dut_grants.size() > 2 ? dut_grants[2] : 99, 0);

    do_rst();
    set_all(100, 0, 100, 100);
    repeat (80) step();
    #1;
    chk("stall_req_tready", bus.req_tready, 0);
    chk("stall_busy", busy, 1);
    chk("stall_eng_out_tready", bus.eng_out_tready, 0);
    set_all(100, 100, 100, 100);
    repeat (80) step();

    for (int blk = 0; blk < 15; blk++) begin
      for (int r = 0; r < N; r++) begin
        p_valid[r] = $urandom_range(100, 20);
        p_rsp[r] = $urandom_range(100, 20);
      end
      p_in = $urandom_range(100, 20);
      p_ov = $urandom_range(100, 20);
      repeat (200) step();
    end
    set_all(0, 100, 100, 100);
    repeat (100) step();
    for (int r = 0; r < N; r++) chk("drain_frames", rf[r], sf[r]);

    do_rst();
    set_all(0, 100, 100, 100);
    p_valid[0] = 100;
    for (int i = 0; i < 50 && !(m_xfer && m_inb == 7); i++) step();
    chk("mid_frame_reached", m_inb, 7);
    rst_req = 1;
    step();
    #1;
    chk("midrst_req_tready", bus.req_tready, 0);
    chk("midrst_eng_in_tvalid", bus.eng_in_tvalid, 0);
    chk("midrst_rsp_tvalid", bus.rsp_tvalid, 0);
    chk("midrst_eng_out_tready", bus.eng_out_tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    rst_req = 0;
    repeat (60) step();
    chk("midrst_new_frame", rf[0] > 0, 1);

`ifdef ARB_TLAST_CHECK_EN
    do_rst();
    set_all(0, 100, 100, 100);
    p_valid[0] = 100;
    bad_beat = 10;
    repeat (30) step();
    chk("frame_err_set", frame_err, 1);
    repeat (20) step();
    chk("frame_err_sticky", frame_err, 1);
    bad_beat = -1;
    do_rst();
    #1 chk("frame_err_cleared", frame_err, 0);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/matrix_stream_arbiter.md
Name: matrix_stream_arbiter

Overview:
- Shares one matrix engine (reverse/transpose class, SIZE x SIZE, AXI-Stream-like ports) among NUM_REQ requester streams.
- Grants are whole-matrix: once a requester is granted, all SIZE*SIZE beats go to the engine before any other requester is served.
- Records the grant order in a small tag FIFO, then routes each engine output matrix back to the requester that supplied it.
- Sits between the requester masters and the engine's in_*/out_* ports.

Parameters:
- SIZE, 4, matrix dimension; frame length FRAME = SIZE*SIZE beats.
- DATA_WIDTH, 32, beat width.
- NUM_REQ, 2, number of requesters (2..8).
- TAG_DEPTH, 2, max matrices in flight inside the engine (engine is double-buffered); power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_tdata  in  NUM_REQ*DATA_WIDTH  requester data, requester r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- req_tvalid  in  NUM_REQ  per-requester valid
- req_tlast  in  NUM_REQ  per-requester last (informational only)
- req_tready  out  NUM_REQ  per-requester ready
- eng_in_tdata  out  DATA_WIDTH  to engine in_tdata
- eng_in_tvalid  out  1  to engine in_tvalid
- eng_in_tlast  out  1  high on beat FRAME-1
- eng_in_tready  in  1  from engine in_tready
- eng_out_tdata  in  DATA_WIDTH  from engine out_tdata
- eng_out_tvalid  in  1  from engine out_tvalid
- eng_out_tlast  in  1  from engine out_tlast
- eng_out_tready  out  1  to engine out_tready
- rsp_tdata  out  DATA_WIDTH  result data, broadcast to all requesters
- rsp_tvalid  out  NUM_REQ  one-hot result valid
- rsp_tlast  out  NUM_REQ  one-hot result last
- rsp_tready  in  NUM_REQ  per-requester result ready
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  high while in XFER or tag FIFO non-empty

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, beat counters=0, tag FIFO empty, busy=0. All req_tready, eng_in_tvalid, eng_out_tready and rsp_tvalid are 0.
- Rst mid-frame: everything is dropped immediately, with no drain. The engine must be reset in the same cycle by the same rst.
- Input FSM, IDLE:
  - If any req_tvalid is high and the tag FIFO is not full, pick the first valid requester at or after rr_ptr (round-robin, wrapping).
  - Register grant_id, push the tag, go to XFER.
  - The grant takes effect 1 cycle after the request is seen.
  - If the FIFO is full, stay in IDLE and grant nothing.
- Input FSM, XFER:
  - Combinational pass-through: eng_in_tdata = granted slice, eng_in_tvalid = req_tvalid[grant_id], req_tready[grant_id] = eng_in_tready. All other req_tready are 0.
  - in_cnt increments on each handshake. eng_in_tlast = (in_cnt==FRAME-1).
  - On the handshake at FRAME-1: in_cnt resets to 0, rr_ptr = grant_id+1 (mod NUM_REQ), state returns to IDLE.
  - Minimum gap between frames is 1 cycle.
- Frame boundaries come from in_cnt only; req_tlast never ends a frame.
- Output router: when the tag FIFO is non-empty, head tag h selects the destination.
  - rsp_tvalid[h] = eng_out_tvalid, rsp_tlast[h] = eng_out_tlast, eng_out_tready = rsp_tready[h].
  - out_cnt counts handshakes. The tag is popped on the handshake where out_cnt==FRAME-1, and out_cnt clears.
  - When the FIFO is empty: eng_out_tready=0, rsp_tvalid=0.
- Simultaneous push (grant) and pop (last result beat) in one cycle: both take effect and the occupancy is unchanged. Full/not-full is evaluated on the registered count, so a grant is allowed when the count is < TAG_DEPTH.
- Backpressure on either side only stalls the beat counters; no beat is lost or duplicated.
- Counter widths are $clog2(FRAME) bits and wrap only by explicit clear.

Optional Feature:
- Macro ARB_TLAST_CHECK_EN.
- When defined, adds output port frame_err (1 bit, sticky, cleared only by rst). frame_err sets if:
  - req_tlast[grant_id] on an accepted beat disagrees with (in_cnt==FRAME-1), or
  - eng_out_tlast on an accepted beat disagrees with (out_cnt==FRAME-1).
- When undefined: no port, no checker logic, and tlast inputs are ignored.

Decomposition:
- Package matrix_ip_pkg holds:
  - the FSM state enum (IDLE, XFER);
  - localparams FRAME, CNT_W, ID_W;
  - a function computing the round-robin pick from a valid mask and a pointer.
- Sub-module arb_tag_fifo: synchronous FIFO, TAG_DEPTH x ID_W, with push/pop/full/empty/head. Simultaneous push+pop is legal when full or empty, as long as the operation itself is legal.

Test Plan:
- Single requester, SIZE=4, req0 sends 0..15 back-to-back, all readies 1 → eng_in sees 16 beats with tlast on beat 15. rsp_tvalid=2'b01 for all 16 result beats, and the tag pops after beat 15.
- Both requesters valid at the same cycle after reset → grant order req0, req1, req0. grant_id sequence 0,1,0. Each result frame routes to its originator, and req1 is never stalled more than FRAME+1 cycles.
- eng_in_tready toggles 1,0,1,0 during a frame → exactly 16 beats are transferred, in_cnt holds on 0 cycles, and data order is preserved.
- Engine output stalled (rsp_tready=0) while 2 frames are accepted → the third request waits in IDLE with req_tready=0. Raising rsp_tready pops a tag, and the grant follows 1 cycle later.
- rst asserted at beat 7 of a frame → the next cycle shows all readies/valids 0, busy=0, grant_id=0, and a new frame starts cleanly from beat 0.
- With ARB_TLAST_CHECK_EN: req_tlast asserted on beat 10 → frame_err=1 one cycle later and stays 1 until rst.
